// File: rtl/icache_pkg.sv
// icache_pkg: shared types, sizes and field helpers
// for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    UPDATE
  } state_t;

  localparam int TAG_W   = 3;
  localparam int INDEX_W = 3;
  localparam int LINE_W  = 128;
  localparam int WORD_W  = 32;
  localparam int LINES   = 1 << INDEX_W;
  localparam int BLK_W   = TAG_W + INDEX_W;

  function automatic logic [TAG_W-1:0] blk_tag(
    input logic [BLK_W-1:0] blk
  );
    return blk[BLK_W-1:INDEX_W];
  endfunction

  function automatic logic [INDEX_W-1:0] blk_index(
    input logic [BLK_W-1:0] blk
  );
    return blk[INDEX_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] line_word(
    input logic [LINE_W-1:0] line,
    input logic [1:0]        w
  );
    return line[w*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: data, tag and valid arrays with
// a combinational read port and one refill write port.
module icache_line_store
  import icache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               flush,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line
);

  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  // Valid bits: cleared by reset or flush, set by refill.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage are never cleared.
  always_ff @(posedge CLK) begin
    if (we) begin
      data_q[wr_index] <= wr_line;
      tag_q[wr_index]  <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/icache_controller.sv
// icache_controller: direct-mapped I-cache, 0-cycle hits,
// single-block refill FSM toward the instruction memory.
module icache_controller #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [31:0]                PC,
  input  logic                       FLUSH,
  output logic [31:0]                INSTRUCTION,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  input  logic [127:0]               MEM_READINST,
  input  logic                       MEM_BUSYWAIT
);

  import icache_pkg::*;

  localparam int BW = ADDR_W - OFFSET_W;

  state_t               state_q;
  state_t               state_d;
  logic [BW-1:0]        blk;
  logic [BW-1:0]        miss_addr_q;
  logic [1:0]           word;
  logic                 seen_busy_q;
  logic                 mem_read_q;
  logic                 hit;
  logic                 serve;
  logic                 fetch_start;
  logic                 flush_en;
  logic                 line_we;
  logic [INDEX_W-1:0]   rd_index;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_W-1:0]    rd_line;
  logic                 unused_pc;

  assign blk       = PC[ADDR_W-1:OFFSET_W];
  assign word      = PC[3:2];
  assign rd_index  = blk_index(blk);
  assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};

  icache_line_store u_store (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush    (flush_en),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (line_we),
    .wr_index (blk_index(miss_addr_q)),
    .wr_tag   (blk_tag(miss_addr_q)),
    .wr_line  (MEM_READINST)
  );

  assign hit   = rd_valid && (rd_tag == blk_tag(blk));
  assign serve = (state_q == IDLE) && hit;

  // Hit path toward the pipeline.
  always_comb begin
    BUSYWAIT    = !serve;
    INSTRUCTION = '0;
    if (serve) begin
      INSTRUCTION = line_word(rd_line, word);
    end
  end

  // Next state; flush wins over a miss in IDLE.
  always_comb begin
    state_d     = state_q;
    fetch_start = 1'b0;
    flush_en    = 1'b0;
    line_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (FLUSH) begin
          flush_en = 1'b1;
        end else if (!hit) begin
          fetch_start = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (seen_busy_q && !MEM_BUSYWAIT) begin
          line_we = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched miss block and memory request.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      mem_read_q  <= 1'b0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_start) begin
        miss_addr_q <= blk;
        mem_read_q  <= 1'b1;
        seen_busy_q <= 1'b0;
      end
      if (state_q == FETCH) begin
        if (MEM_BUSYWAIT) begin
          seen_busy_q <= 1'b1;
        end
        if (line_we) begin
          mem_read_q <= 1'b0;
        end
      end
    end
  end

  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = miss_addr_q;

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped instruction cache controller between the IF stage and the 128-bit block instruction memory (1024 bytes, 64 blocks of 16 bytes, BUSYWAIT handshake).
- Serves hits combinationally.
- On a miss, stalls the pipeline, sequences one block read and refills the line.
- Owns the tag/valid/data arrays and the refill state machine.

Parameters:
- ADDR_W, 10, byte-address bits used from PC (PC[31:ADDR_W] ignored)
- INDEX_W, 3, line index bits (2**INDEX_W = 8 lines)
- OFFSET_W, 4, byte offset within a 16-byte line (fixed; word select = PC[3:2])

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- PC  in  32  fetch byte address from the IF stage; PC[1:0] ignored
- FLUSH  in  1  level request to invalidate all lines
- INSTRUCTION  out  32  fetched instruction; valid when BUSYWAIT=0
- BUSYWAIT  out  1  stall request to the pipeline
- MEM_READ  out  1  block read request to the instruction memory
- MEM_ADDRESS  out  6  block address {tag, index} = PC[9:4] of the missing line
- MEM_READINST  in  128  block data; byte k of line = MEM_READINST[8k+7:8k]
- MEM_BUSYWAIT  in  1  memory busy; falling edge (1->0) marks data valid

Behaviour:
- Address split: tag = PC[9:7], index = PC[6:4], word = PC[3:2].
- Word w = line[32w+31:32w], little-endian.
- Reset (async): state=IDLE; all valid bits=0; MEM_READ=0; MEM_ADDRESS=0.
  - Tag/data arrays are not cleared.
  - INSTRUCTION=0; BUSYWAIT follows the hit logic, so it is 1 immediately after reset because all lines are invalid.
- hit = valid[index] && tag_array[index]==tag, evaluated combinationally from the current PC.
- IDLE:
  - hit: BUSYWAIT=0; INSTRUCTION=selected word in the same cycle (0-cycle hit latency).
  - miss: BUSYWAIT=1; INSTRUCTION=0. At the next posedge, latch miss_addr=PC[9:4] and go to FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS=miss_addr, BUSYWAIT=1.
  - Stay while MEM_BUSYWAIT=1, or while MEM_BUSYWAIT has not yet risen since entry. Track a seen_busy flag, set at the first posedge with MEM_BUSYWAIT=1.
  - At the first posedge with seen_busy=1 and MEM_BUSYWAIT=0:
    - write MEM_READINST into data[miss_addr[2:0]]; tag_array=miss_addr[5:3]; valid=1;
    - drop MEM_READ; go to UPDATE.
- UPDATE: one cycle; BUSYWAIT=1, MEM_READ=0; go to IDLE. The re-lookup then uses the current PC.
- Miss penalty: 1 (detect) + memory latency + 1 (UPDATE) cycles.
- PC change during FETCH: the refill completes for the latched miss_addr only. If the new PC also misses, a fresh miss is taken from IDLE.
- FLUSH:
  - Clears all valid bits at any posedge where state==IDLE.
  - In FETCH/UPDATE it is not acted on; the refill completes, and FLUSH (if still high) clears on the first IDLE edge.
  - FLUSH in IDLE takes priority over a simultaneous miss: the same edge clears valids, and the miss is taken on the next edge.
- Reset mid-FETCH: MEM_READ deasserts asynchronously, the in-flight refill is abandoned, and no line is written.
- Outputs MEM_READ and MEM_ADDRESS are registered. BUSYWAIT and INSTRUCTION are combinational from state, PC and the arrays.

Decomposition:
- Shared package icache_pkg:
  - state enum {IDLE, FETCH, UPDATE}
  - localparams TAG_W=3, INDEX_W=3, LINE_W=128, WORD_W=32
  - field-extraction functions for tag, index and word.
- One sub-module icache_line_store:
  - 8x128 data array, 8x3 tag array, 8-bit valid register with async clear and flush-clear
  - combinational read port (index) and one write port (index, tag, line).
- The FSM stays in icache_controller.

Test Plan:
- Cold miss: reset, PC=0x0, memory latency 5 cycles, line0 words {0x00800093, 0x00108113, 0x00210193, 0x00318213} -> BUSYWAIT=1; MEM_READ=1, MEM_ADDRESS=0 for the memory window; then INSTRUCTION=0x00800093, BUSYWAIT=0.
- Hit sequence: after the cold miss, PC=0x4,0x8,0xC on consecutive cycles -> BUSYWAIT=0 each cycle; INSTRUCTION=0x00108113, 0x00210193, 0x00318213; MEM_READ stays 0.
- Conflict: PC=0x80 (index 0, tag 1) -> miss, MEM_ADDRESS=0x08. Then PC=0x0 -> miss again (line evicted), MEM_ADDRESS=0x00.
- PC change mid-refill: miss on PC=0x10, switch PC to 0x20 during FETCH -> line 1 filled; then a second miss with MEM_ADDRESS=0x02; finally hit on 0x20.
- FLUSH: lines 0 and 1 valid, FLUSH=1 for one IDLE cycle -> next access to PC=0x4 misses, MEM_READ=1, MEM_ADDRESS=0.
- Reset mid-FETCH: assert RESET 2 cycles into FETCH of PC=0x30 -> MEM_READ=0 immediately; after release, PC=0x30 misses again and MEM_ADDRESS=0x03.
